// File: rtl/bus_pkg.sv
// bus_pkg: shared types, default widths and helpers for the bus/run-control slice.
package bus_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_N_SRC = 6;
   localparam int DEF_CNT_W = 8;
   typedef enum logic [1:0] {RUN, HALTED, STEP} run_state_t;
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   function automatic logic isMulti(input logic [63:0] en);
      return (en & (en - 64'd1)) != 64'd0;
   endfunction
endpackage

// File: rtl/bus_run_fsm.sv
// bus_run_fsm: run/halt/single-step FSM producing the datapath clock enable.
module bus_run_fsm
   import bus_pkg::*;
#(
   parameter int CONT_HALT = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_contEvt,
   input  logic i_ctrlHlt,
   input  logic i_button,
   input  logic i_stepMode,
   output logic o_clkEn,
   output logic o_halted
);
   run_state_t state, nextState, runNext;
   logic r_btnPrev, r_hltMask, btnEdge;
   assign btnEdge = i_button & ~r_btnPrev;
   // The mask only survives the first enabled cycle after leaving HALTED.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state     <= RUN;
         r_btnPrev <= 1'b0;
         r_hltMask <= 1'b0;
      end else begin
         state     <= nextState;
         r_btnPrev <= i_button;
         r_hltMask <= (state == HALTED) & btnEdge;
      end
   end
   always_comb begin
      runNext   = ((i_contEvt && CONT_HALT != 0) || (i_ctrlHlt && !r_hltMask) || i_stepMode) ? HALTED : RUN;
      nextState = (state == RUN)    ? runNext :
                  (state == HALTED) ? (btnEdge ? (i_stepMode ? STEP : RUN) : HALTED) : HALTED;
   end
   always_comb begin
      o_clkEn  = (state == RUN) || (state == STEP);
      o_halted = (state == HALTED);
   end
endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl: one-hot N-source bus mux with keeper, contention statistics and run control.
module bus_ctrl
   import bus_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int N_SRC     = DEF_N_SRC,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int CONT_HALT = 1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [N_SRC*DATA_W-1:0] i_srcData,
   input  logic [N_SRC-1:0]        i_srcEn,
   output logic [DATA_W-1:0]       o_bus,
   output logic                    o_busValid,
   input  logic                    i_ctrlHlt,
   input  logic                    i_button,
   input  logic                    i_stepMode,
   input  logic                    i_clrErr,
   output logic                    o_clkEn,
   output logic                    o_halted,
   output logic                    o_contention,
   output logic [CNT_W-1:0]        o_contCount,
   output logic [N_SRC-1:0]        o_lastContMask
);
   logic [DATA_W-1:0] r_keep, selData;
   logic multi, oneHot, contEvt;
   // OR of enabled sources is only used when exactly one is enabled.
   always_comb begin
      selData = '0;
      for (int k = 0; k < N_SRC; k++)
         selData = selData | (i_srcEn[k] ? i_srcData[k*DATA_W +: DATA_W] : '0);
   end
   assign multi      = isMulti(64'(i_srcEn));
   assign oneHot     = (|i_srcEn) & ~multi;
   assign contEvt    = multi & o_clkEn;
   assign o_bus      = oneHot ? selData : r_keep;
   assign o_busValid = oneHot;
   always_ff @(posedge i_clk) begin
      if (!i_reset) r_keep <= '0;
      else if (oneHot) r_keep <= selData;
   end
   // An event in the same cycle as a clear restarts the statistics at one.
   always_ff @(posedge i_clk) begin
      if (!i_reset || (i_clrErr && !contEvt)) begin
         o_contention   <= 1'b0;
         o_contCount    <= '0;
         o_lastContMask <= '0;
      end else if (contEvt) begin
         o_contention   <= 1'b1;
         o_contCount    <= i_clrErr ? CNT_W'(1) : (&o_contCount ? o_contCount : o_contCount + CNT_W'(1));
         o_lastContMask <= i_srcEn;
      end
   end
   bus_run_fsm #(.CONT_HALT(CONT_HALT)) u_fsm (
      .i_clk(i_clk), .i_reset(i_reset), .i_contEvt(contEvt), .i_ctrlHlt(i_ctrlHlt),
      .i_button(i_button), .i_stepMode(i_stepMode), .o_clkEn(o_clkEn), .o_halted(o_halted)
   );
endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: directed stimulus with a queued scoreboard checked by a mid-cycle monitor.
module tb_bus_ctrl;
   logic clk = 1'b0, rst = 1'b0;
   logic [47:0] srcData;
   logic [5:0] srcEn = '0, srcEn1 = '0;
   logic ctrlHlt = 1'b0, button = 1'b0, stepMode = 1'b0, clrErr = 1'b0;
   logic [7:0] bus0, bus1, cnt0, cnt1;
   logic [5:0] mask0, mask1;
   logic v0, v1, ce0, ce1, h0, h1, ct0, ct1;
   int tests = 0, failed = 0;
   typedef struct {
      string nm; int dut; logic [7:0] bus; logic valid, clkEn, halted, cont;
      logic [7:0] cnt; logic [5:0] mask;
   } exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   assign srcData = {8'h66, 8'h5A, 8'h44, 8'hA5, 8'h22, 8'h11};
   bus_ctrl #(.DATA_W(8), .N_SRC(6), .CNT_W(8), .CONT_HALT(1)) u0 (
      .i_clk(clk), .i_reset(rst), .i_srcData(srcData), .i_srcEn(srcEn), .o_bus(bus0),
      .o_busValid(v0), .i_ctrlHlt(ctrlHlt), .i_button(button), .i_stepMode(stepMode),
      .i_clrErr(clrErr), .o_clkEn(ce0), .o_halted(h0), .o_contention(ct0),
      .o_contCount(cnt0), .o_lastContMask(mask0));
   bus_ctrl #(.DATA_W(8), .N_SRC(6), .CNT_W(8), .CONT_HALT(0)) u1 (
      .i_clk(clk), .i_reset(rst), .i_srcData(srcData), .i_srcEn(srcEn1), .o_bus(bus1),
      .o_busValid(v1), .i_ctrlHlt(ctrlHlt), .i_button(button), .i_stepMode(stepMode),
      .i_clrErr(clrErr), .o_clkEn(ce1), .o_halted(h1), .o_contention(ct1),
      .o_contCount(cnt1), .o_lastContMask(mask1));
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         e = q.pop_front();
         a = e;
         {a.bus, a.valid, a.clkEn, a.halted, a.cont, a.cnt, a.mask} = (e.dut == 0) ?
            {bus0, v0, ce0, h0, ct0, cnt0, mask0} : {bus1, v1, ce1, h1, ct1, cnt1, mask1};
         tests++;
         if ({a.bus, a.valid, a.clkEn, a.halted, a.cont, a.cnt, a.mask} !==
             {e.bus, e.valid, e.clkEn, e.halted, e.cont, e.cnt, e.mask}) begin
            failed++;
            $display("FAIL %s: got bus=%h v=%b ce=%b h=%b ct=%b n=%0d m=%b, want bus=%h v=%b ce=%b h=%b ct=%b n=%0d m=%b",
               e.nm, a.bus, a.valid, a.clkEn, a.halted, a.cont, a.cnt, a.mask,
               e.bus, e.valid, e.clkEn, e.halted, e.cont, e.cnt, e.mask);
         end
      end
   end
   task automatic tick(input bit chk, input string nm, input int d, input logic [7:0] b,
                       input logic v, input logic c, input logic h, input logic ct,
                       input logic [7:0] n, input logic [5:0] m);
      if (chk) q.push_back('{nm, d, b, v, c, h, ct, n, m});
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      tick(0, "", 0, '0, 0, 0, 0, 0, '0, '0);
   endtask
   initial begin
      #1;
      idle();
      rst = 1'b1;
      tick(1, "reset", 0, 8'h00, 0, 1, 0, 0, 0, 6'b0);
      srcEn = 6'b000100;
      tick(1, "single", 0, 8'hA5, 1, 1, 0, 0, 0, 6'b0);
      srcEn = 6'b0;
      tick(1, "keep", 0, 8'hA5, 0, 1, 0, 0, 0, 6'b0);
      srcEn = 6'b010010;
      tick(1, "contCyc", 0, 8'hA5, 0, 1, 0, 0, 0, 6'b0);
      srcEn = 6'b0;
      tick(1, "contHalt", 0, 8'hA5, 0, 0, 1, 1, 1, 6'b010010);
      srcEn = 6'b010010;
      tick(1, "haltIgn", 0, 8'hA5, 0, 0, 1, 1, 1, 6'b010010);
      srcEn = 6'b0;
      tick(1, "haltIgn2", 0, 8'hA5, 0, 0, 1, 1, 1, 6'b010010);
      button = 1'b1; idle();
      button = 1'b0; srcEn = 6'b000011;
      tick(1, "resumeCont", 0, 8'hA5, 0, 1, 0, 1, 1, 6'b010010);
      srcEn = 6'b0; idle();
      button = 1'b1; idle();
      button = 1'b0; srcEn = 6'b000011; idle();
      srcEn = 6'b0; button = 1'b1; idle();
      button = 1'b0; srcEn = 6'b000011; clrErr = 1'b1;
      tick(1, "preClr", 0, 8'hA5, 0, 1, 0, 1, 3, 6'b000011);
      srcEn = 6'b0; clrErr = 1'b0;
      tick(1, "clrEvt", 0, 8'hA5, 0, 0, 1, 1, 1, 6'b000011);
      clrErr = 1'b1; idle();
      clrErr = 1'b0;
      tick(1, "clr", 0, 8'hA5, 0, 0, 1, 0, 0, 6'b0);
      button = 1'b1; idle();
      button = 1'b0; srcEn = 6'b000001;
      tick(1, "run", 0, 8'h11, 1, 1, 0, 0, 0, 6'b0);
      srcEn = 6'b0; ctrlHlt = 1'b1;
      tick(1, "hltCyc", 0, 8'h11, 0, 1, 0, 0, 0, 6'b0);
      tick(1, "hlt", 0, 8'h11, 0, 0, 1, 0, 0, 6'b0);
      button = 1'b1; idle();
      button = 1'b0;
      tick(1, "noReHlt", 0, 8'h11, 0, 1, 0, 0, 0, 6'b0);
      tick(1, "reHltCyc", 0, 8'h11, 0, 1, 0, 0, 0, 6'b0);
      tick(1, "reHlt", 0, 8'h11, 0, 0, 1, 0, 0, 6'b0);
      ctrlHlt = 1'b0; stepMode = 1'b1; button = 1'b1;
      tick(1, "stepA", 0, 8'h11, 0, 0, 1, 0, 0, 6'b0);
      tick(1, "stepB", 0, 8'h11, 0, 1, 0, 0, 0, 6'b0);
      for (int i = 0; i < 3; i++) tick(1, "stepHeld", 0, 8'h11, 0, 0, 1, 0, 0, 6'b0);
      button = 1'b0;
      tick(1, "stepRel", 0, 8'h11, 0, 0, 1, 0, 0, 6'b0);
      button = 1'b1;
      tick(1, "step2Edge", 0, 8'h11, 0, 0, 1, 0, 0, 6'b0);
      srcEn = 6'b011000;
      tick(1, "step2", 0, 8'h11, 0, 1, 0, 0, 0, 6'b0);
      srcEn = 6'b0;
      tick(1, "step2Hlt", 0, 8'h11, 0, 0, 1, 1, 1, 6'b011000);
      button = 1'b0; idle();
      button = 1'b1; idle();
      rst = 1'b0;
      tick(1, "stepRst", 0, 8'h11, 0, 1, 0, 1, 1, 6'b011000);
      rst = 1'b1; button = 1'b0; stepMode = 1'b0;
      tick(1, "afterRst", 0, 8'h00, 0, 1, 0, 0, 0, 6'b0);
      rst = 1'b0; idle();
      rst = 1'b1; srcEn1 = 6'b000011;
      for (int i = 0; i < 300; i++)
         tick(i == 200, "sat200", 1, 8'h00, 0, 1, 0, 1, 200, 6'b000011);
      srcEn1 = 6'b0;
      tick(1, "sat", 1, 8'h00, 0, 1, 0, 1, 255, 6'b000011);
      repeat (2) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1);
   end
endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Parametrised shared-bus and run-control block for the CPU datapath.
- Replaces the single fixed 8-bit bus with an N-source, one-hot-enabled bus mux. Adds a bus keeper, contention detection/statistics, and a run/halt/single-step clock-enable FSM.
- Sits between all bus drivers (ALU, regset, RAM, PC, IO, immediate) and all bus consumers. Its o_clkEn qualifies every sequential unit.

Parameters:
- DATA_W, 8, bus width in bits.
- N_SRC, 6, number of bus sources.
- CNT_W, 8, width of the saturating contention counter.
- CONT_HALT, 1, 1 = a contention event forces the FSM to HALTED.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous reset, active-low (0 = reset).
- i_srcData  in  N_SRC*DATA_W  packed source data; source k occupies bits [k*DATA_W +: DATA_W].
- i_srcEn  in  N_SRC  active-high per-source drive enables.
- o_bus  out  DATA_W  resolved bus value.
- o_busValid  out  1  exactly one source enabled this cycle.
- i_ctrlHlt  in  1  halt request from control unit.
- i_button  in  1  resume/step button (already synchronised).
- i_stepMode  in  1  1 = single-step operation.
- i_clrErr  in  1  clear contention status.
- o_clkEn  out  1  clock enable for all datapath units.
- o_halted  out  1  FSM in HALTED.
- o_contention  out  1  sticky contention flag.
- o_contCount  out  CNT_W  saturating contention event count.
- o_lastContMask  out  N_SRC  i_srcEn value of the most recent contention.

Behaviour:
- Bus resolution (combinational, 0 latency):
  - Exactly one enable: o_bus = that source's data; o_busValid = 1.
  - Zero enables: o_bus = r_keep; o_busValid = 0.
  - Two or more enables: o_bus = r_keep (no OR-merge); o_busValid = 0.
- Keeper r_keep:
  - Loads o_bus on every cycle with exactly one enable, regardless of o_clkEn.
  - Reset value 0.
- Contention event = (popcount(i_srcEn) >= 2) & o_clkEn. Enables seen while halted are ignored.
  - On an event: o_contention <= 1; o_contCount <= min(count+1, 2^CNT_W-1); o_lastContMask <= i_srcEn.
  - i_clrErr zeroes all three.
  - Simultaneous clear and event: the event wins (flag=1, count=1, mask=new).
- Button edge: r_btnPrev is registered (reset 0); btnEdge = i_button & ~r_btnPrev. A held button produces exactly one edge.
- FSM states RUN, HALTED, STEP; state is registered. o_clkEn = (state==RUN) | (state==STEP); o_halted = (state==HALTED).
  - RUN transitions, in priority order:
    - Contention event with CONT_HALT=1 -> HALTED.
    - i_ctrlHlt=1 with r_hltMask=0 -> HALTED.
    - i_stepMode=1 -> HALTED.
    - Otherwise stay in RUN.
  - The cycle in which the halt cause is seen still has o_clkEn=1, so the HLT instruction's cycle completes.
  - HALTED: btnEdge -> STEP if i_stepMode, else RUN. All other inputs are ignored.
  - STEP: unconditionally -> HALTED after its single enabled cycle. Contention or i_ctrlHlt in this cycle is still recorded, and the destination is still HALTED.
- r_hltMask:
  - Set on every HALTED->RUN or HALTED->STEP transition; cleared after the first enabled cycle.
  - This suppresses i_ctrlHlt for exactly that first cycle, because the control unit's halt output is frozen while the clock is gated.
- Reset (i_reset=0, synchronous):
  - Outputs: state=RUN, o_clkEn=1, o_halted=0.
  - State: r_keep=0, r_btnPrev=0, r_hltMask=0.
  - Contention: flag=0, count=0, mask=0.
  - Reset has priority over every other input, including mid-STEP and mid-contention.

Decomposition:
- Package bus_pkg:
  - typedef enum logic[1:0] {RUN, HALTED, STEP} run_state_t.
  - Popcount-to-"multiple" helper function.
  - Default width constants.
- Sub-module bus_run_fsm: state register, button edge detector, r_hltMask, o_clkEn/o_halted.
- Top level: bus mux, keeper, contention statistics.

Test Plan:
- Single-source drive: DATA_W=8, N_SRC=6; i_srcEn=6'b000100, src2=8'hA5 -> o_bus=8'hA5, o_busValid=1 the same cycle. Next cycle i_srcEn=0 -> o_bus stays 8'hA5, o_busValid=0.
- Contention: i_srcEn=6'b010010 for 1 cycle with CONT_HALT=1 -> o_bus=keeper value, o_contention=1, o_contCount=1, o_lastContMask=6'b010010; o_halted=1 next cycle.
- Clear/event collision: with count=3, assert i_clrErr together with a new contention (mask 6'b000011) -> count=1, mask=6'b000011, flag=1. Separately, hold contention 300 cycles with CONT_HALT=0, CNT_W=8 -> count saturates at 255.
- Halt and resume: pulse i_ctrlHlt in RUN -> o_clkEn=1 that cycle, 0 afterwards. Keep i_ctrlHlt=1 and press i_button once -> RUN, and no re-halt in the first enabled cycle. i_ctrlHlt still 1 on the second enabled cycle -> HALTED.
- Single step: i_stepMode=1 while HALTED; hold i_button high for 5 cycles -> exactly one o_clkEn=1 pulse, then HALTED. Release and press again -> one more pulse.
- Reset mid-STEP: drive i_reset=0 during STEP with contention flag set -> next cycle state=RUN, o_clkEn=1, all status outputs 0, o_bus=0 with no enables.
